// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction-fetch front end.
// Owns the fetch PC, issues in-order requests to instruction memory, parks
// each returned word (with its PC) in a circular buffer, and hands
// instructions to decode over valid/ready. A redirect flushes the buffer
// and turns every response still in flight into one to be discarded.
module fetch_unit #(
    parameter int          XLEN       = 64,
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int          IBUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc
);

    localparam int PW = $clog2(IBUF_DEPTH);
    localparam int CW = PW + 1;

    // Architectural state
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [PW-1:0]   alloc_ptr_reg, alloc_ptr_next;
    logic [PW-1:0]   fill_ptr_reg, fill_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   reserved_reg, reserved_next;
    logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
    // Requests accepted whose responses are still owed to a live slot
    // (i.e. not already accounted for in drop_cnt).
    logic [CW-1:0]   inflight_reg, inflight_next;
    logic            started_reg;

    logic [XLEN-1:0] slot_pc_reg     [IBUF_DEPTH];
    logic [31:0]     slot_instr_reg  [IBUF_DEPTH];
    logic            slot_filled_reg [IBUF_DEPTH];

    // Handshake qualifiers
    logic [CW:0] credit_used;
    logic        has_credit;
    logic        req_fire;
    logic        alloc_en;
    logic        rsp_keep;
    logic        dec_fire;

    assign credit_used    = {1'b0, reserved_reg} + {1'b0, drop_cnt_reg};
    assign has_credit     = credit_used < (CW+1)'(IBUF_DEPTH);
    assign imem_req_valid = started_reg && has_credit;
    assign imem_req_addr  = fetch_pc_reg;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign alloc_en = req_fire && !redirect_valid;
    // A response is written only when nothing is pending discard and no
    // flush is happening in the same cycle.
    assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_cnt_reg == '0);

    assign instr_valid = slot_filled_reg[rd_ptr_reg];
    assign instr_o     = slot_instr_reg[rd_ptr_reg];
    assign instr_pc    = slot_pc_reg[rd_ptr_reg];
    assign dec_fire    = instr_valid && instr_ready;

    // Next-state for PC, pointers and the credit counters
    always_comb begin
        fetch_pc_next  = fetch_pc_reg;
        alloc_ptr_next = alloc_ptr_reg;
        fill_ptr_next  = fill_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        reserved_next  = reserved_reg;
        inflight_next  = inflight_reg;
        drop_cnt_next  = drop_cnt_reg;
        if (redirect_valid) begin
            fetch_pc_next  = redirect_pc & ~XLEN'(3);
            alloc_ptr_next = '0;
            fill_ptr_next  = '0;
            rd_ptr_next    = '0;
            reserved_next  = '0;
            inflight_next  = '0;
            // Everything still owed by memory, including a request taken
            // this cycle, minus the response that is arriving right now.
            drop_cnt_next  = drop_cnt_reg + inflight_reg + CW'(req_fire)
                             - CW'(imem_rsp_valid);
        end else begin
            if (alloc_en) begin
                fetch_pc_next  = fetch_pc_reg + XLEN'(4);
                alloc_ptr_next = alloc_ptr_reg + PW'(1);
            end
            if (rsp_keep) begin
                fill_ptr_next = fill_ptr_reg + PW'(1);
            end
            if (dec_fire) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            reserved_next = reserved_reg + CW'(alloc_en) - CW'(dec_fire);
            inflight_next = inflight_reg + CW'(alloc_en) - CW'(rsp_keep);
            if (imem_rsp_valid && (drop_cnt_reg != '0)) begin
                drop_cnt_next = drop_cnt_reg - CW'(1);
            end
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg  <= RESET_PC[XLEN-1:0];
            alloc_ptr_reg <= '0;
            fill_ptr_reg  <= '0;
            rd_ptr_reg    <= '0;
            reserved_reg  <= '0;
            inflight_reg  <= '0;
            drop_cnt_reg  <= '0;
            started_reg   <= 1'b0;
        end else begin
            fetch_pc_reg  <= fetch_pc_next;
            alloc_ptr_reg <= alloc_ptr_next;
            fill_ptr_reg  <= fill_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            reserved_reg  <= reserved_next;
            inflight_reg  <= inflight_next;
            drop_cnt_reg  <= drop_cnt_next;
            started_reg   <= 1'b1;
        end
    end

    // One register set per buffer slot; allocate, fill and consume always
    // target distinct slots, so their updates never collide.
    for (genvar gi = 0; gi < IBUF_DEPTH; gi++) begin : g_slot
        // Slot update: PC on allocate, data on fill, filled flag tracks occupancy
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_pc_reg[gi]     <= '0;
                slot_instr_reg[gi]  <= '0;
                slot_filled_reg[gi] <= 1'b0;
            end else if (redirect_valid) begin
                slot_filled_reg[gi] <= 1'b0;
            end else begin
                if (alloc_en && (alloc_ptr_reg == PW'(gi))) begin
                    slot_pc_reg[gi]     <= fetch_pc_reg;
                    slot_filled_reg[gi] <= 1'b0;
                end
                if (rsp_keep && (fill_ptr_reg == PW'(gi))) begin
                    slot_instr_reg[gi]  <= imem_rsp_data;
                    slot_filled_reg[gi] <= 1'b1;
                end
                if (dec_fire && (rd_ptr_reg == PW'(gi))) begin
                    slot_filled_reg[gi] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A behavioural memory returns a word derived from each address after a
// chosen latency; the reference model is the program-order stream itself:
// requests and decoded PCs must each run +4 from the last reset/redirect
// target, and every decoded word must be the memory word for its PC.
module tb_fetch_unit;

    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          D        = 4;

    logic            clk;
    logic            rst_n;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] instr_pc;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .IBUF_DEPTH(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_o       (instr_o),
        .instr_pc      (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;
    mreq_t mem_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int k_lat    = 1;
    bit k_rand   = 1'b0;

    // Drive requests for the next cycle
    bit          drv_req_ready   = 1'b0;
    bit          drv_instr_ready = 1'b0;
    bit          drv_redirect    = 1'b0;
    logic [63:0] drv_redirect_pc = '0;

    // Values sampled mid-cycle
    int          s_cyc;
    bit          s_req_valid, s_req_fire, s_instr_valid, s_dec_fire, s_rsp, s_redirect;
    logic [63:0] s_req_addr, s_pc, s_rpc;
    logic [31:0] s_instr;

    // Reference program-order expectations
    logic [63:0] exp_req;
    logic [63:0] exp_dec;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[31:2], 2'b01} ^ a[63:32] ^ 32'h5A3C_96E1;
    endfunction

    // One clock cycle: memory response, apply drives, sample, clock edge
    task automatic step();
        mreq_t r;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(r.addr);
        end
        imem_req_ready = drv_req_ready;
        instr_ready    = drv_instr_ready;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        #1;
        s_cyc         = cyc;
        s_req_valid   = imem_req_valid;
        s_req_addr    = imem_req_addr;
        s_req_fire    = imem_req_valid && imem_req_ready;
        s_instr_valid = instr_valid;
        s_dec_fire    = instr_valid && instr_ready;
        s_pc          = instr_pc;
        s_instr       = instr_o;
        s_rsp         = imem_rsp_valid;
        s_redirect    = redirect_valid;
        s_rpc         = redirect_pc;
        if (s_dec_fire)
            $display("cyc %0d decode pc=%h instr=%h", s_cyc, s_pc, s_instr);
        @(posedge clk);
        if (s_req_fire) begin
            r.addr = s_req_addr;
            r.due  = cyc + (k_rand ? int'($urandom_range(1, 4)) : k_lat);
            mem_q.push_back(r);
        end
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        drv_req_ready  = 1'b0;
        drv_instr_ready = 1'b0;
        drv_redirect   = 1'b0;
        mem_q.delete();
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        cyc     = 0;
        exp_req = RESET_PC;
        exp_dec = RESET_PC;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b0;
        #12;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b want=0", instr_valid); end
        checks++; if (instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr_o got=%h want=0", instr_o); end
        checks++; if (instr_pc !== 64'h0) begin failures++; $display("FAIL reset_instr_pc got=%h want=0", instr_pc); end
        checks++; if (imem_req_addr !== RESET_PC) begin failures++; $display("FAIL reset_req_addr got=%h want=%h", imem_req_addr, RESET_PC); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL release_req_valid got=%b want=1", imem_req_valid); end
    endtask

    task automatic test_stream();
        int first_acc = -1, first_val = -1, miss = 0;
        apply_reset();
        k_rand = 1'b0; k_lat = 1; drv_req_ready = 1'b1; drv_instr_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (s_req_fire) begin
                if (first_acc < 0) first_acc = s_cyc;
                checks++; if (s_req_addr !== exp_req) begin failures++; $display("FAIL stream_req_addr got=%h want=%h", s_req_addr, exp_req); end
                exp_req += 4;
            end
            if (s_instr_valid && first_val < 0) first_val = s_cyc;
            if (s_dec_fire) begin
                checks++; if (s_pc !== exp_dec) begin failures++; $display("FAIL stream_pc got=%h want=%h", s_pc, exp_dec); end
                checks++; if (s_instr !== mem_word(exp_dec)) begin failures++; $display("FAIL stream_instr got=%h want=%h", s_instr, mem_word(exp_dec)); end
                exp_dec += 4;
            end
            if (i >= 4 && !s_instr_valid) miss++;
        end
        checks++; if (first_acc !== 0) begin failures++; $display("FAIL stream_first_accept got=%0d want=0", first_acc); end
        checks++; if (first_val - first_acc !== 2) begin failures++; $display("FAIL stream_latency got=%0d want=2", first_val - first_acc); end
        checks++; if (miss !== 0) begin failures++; $display("FAIL stream_throughput bubbles=%0d want=0", miss); end
    endtask

    task automatic test_backpressure();
        int acc = 0, got = 0;
        bit seen_resume = 1'b0;
        apply_reset();
        k_rand = 1'b0; k_lat = 1; drv_req_ready = 1'b1; drv_instr_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_req_fire) begin
                checks++; if (s_req_addr !== exp_req) begin failures++; $display("FAIL bp_req_addr got=%h want=%h", s_req_addr, exp_req); end
                exp_req += 4; acc++;
            end
        end
        checks++; if (acc !== D) begin failures++; $display("FAIL bp_accept_count got=%0d want=%0d", acc, D); end
        checks++; if (s_req_valid !== 1'b0) begin failures++; $display("FAIL bp_full_req_valid got=%b want=0", s_req_valid); end
        drv_instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_dec_fire) begin
                checks++; if (s_pc !== exp_dec) begin failures++; $display("FAIL bp_pc got=%h want=%h", s_pc, exp_dec); end
                exp_dec += 4; got++;
            end
            if (s_req_fire && !seen_resume) begin
                seen_resume = 1'b1;
                checks++; if (s_req_addr !== RESET_PC + 64'h10) begin failures++; $display("FAIL bp_resume_addr got=%h want=%h", s_req_addr, RESET_PC + 64'h10); end
            end
        end
        checks++; if (got < D) begin failures++; $display("FAIL bp_drain_count got=%0d want>=%0d", got, D); end
    endtask

    task automatic test_redirect_k3();
        bit seen_dec = 1'b0;
        apply_reset();
        k_rand = 1'b0; k_lat = 3; drv_req_ready = 1'b1; drv_instr_ready = 1'b1;
        step(); step();
        drv_req_ready = 1'b0; drv_redirect = 1'b1; drv_redirect_pc = 64'h8000_0103;
        step();
        drv_redirect = 1'b0; drv_req_ready = 1'b1;
        step();
        checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 64'h8000_0100) begin failures++; $display("FAIL k3_next_req valid=%b addr=%h want 1/%h", s_req_valid, s_req_addr, 64'h8000_0100); end
        for (int i = 0; i < 14; i++) begin
            step();
            if (s_dec_fire && !seen_dec) begin
                seen_dec = 1'b1;
                checks++; if (s_pc !== 64'h8000_0100) begin failures++; $display("FAIL k3_first_pc got=%h want=%h", s_pc, 64'h8000_0100); end
                checks++; if (s_instr !== mem_word(64'h8000_0100)) begin failures++; $display("FAIL k3_first_instr got=%h want=%h", s_instr, mem_word(64'h8000_0100)); end
            end
        end
        checks++; if (seen_dec !== 1'b1) begin failures++; $display("FAIL k3_no_decode got=0 want=1"); end
    endtask

    task automatic test_redirect_collision();
        int got = 0;
        apply_reset();
        k_rand = 1'b0; k_lat = 1; drv_req_ready = 1'b1; drv_instr_ready = 1'b1;
        repeat (6) begin
            step();
            if (s_req_fire) exp_req += 4;
            if (s_dec_fire) exp_dec += 4;
        end
        drv_redirect = 1'b1; drv_redirect_pc = 64'h8000_2002;
        step();
        drv_redirect = 1'b0;
        checks++; if (!(s_req_fire && s_rsp)) begin failures++; $display("FAIL coll_setup req_fire=%b rsp=%b want 1/1", s_req_fire, s_rsp); end
        exp_req = 64'h8000_2000; exp_dec = 64'h8000_2000;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_req_fire) begin
                checks++; if (s_req_addr !== exp_req) begin failures++; $display("FAIL coll_req_addr got=%h want=%h", s_req_addr, exp_req); end
                exp_req += 4;
            end
            if (s_dec_fire) begin
                checks++; if (s_pc !== exp_dec || s_instr !== mem_word(exp_dec)) begin failures++; $display("FAIL coll_decode pc=%h instr=%h want %h/%h", s_pc, s_instr, exp_dec, mem_word(exp_dec)); end
                exp_dec += 4; got++;
            end
        end
        checks++; if (got < 6) begin failures++; $display("FAIL coll_decode_count got=%0d want>=6", got); end
    endtask

    task automatic test_stall();
        logic [63:0] held;
        apply_reset();
        k_rand = 1'b0; k_lat = 1; drv_req_ready = 1'b1; drv_instr_ready = 1'b1;
        repeat (3) begin
            step();
            if (s_req_fire) exp_req += 4;
        end
        held = exp_req;
        drv_req_ready = 1'b0;
        repeat (5) begin
            step();
            checks++; if (s_req_valid !== 1'b1 || s_req_addr !== held) begin failures++; $display("FAIL stall_hold valid=%b addr=%h want 1/%h", s_req_valid, s_req_addr, held); end
        end
        drv_req_ready = 1'b1;
        step();
        checks++; if (s_req_fire !== 1'b1 || s_req_addr !== held) begin failures++; $display("FAIL stall_release fire=%b addr=%h want 1/%h", s_req_fire, s_req_addr, held); end
    endtask

    task automatic test_async_reset();
        int got = 0;
        bit first = 1'b1;
        apply_reset();
        k_rand = 1'b0; k_lat = 1; drv_req_ready = 1'b1; drv_instr_ready = 1'b1;
        repeat (7) step();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL async_valids req=%b instr=%b want 0/0", imem_req_valid, instr_valid); end
        checks++; if (instr_o !== 32'h0 || instr_pc !== 64'h0) begin failures++; $display("FAIL async_outputs instr=%h pc=%h want 0/0", instr_o, instr_pc); end
        checks++; if (imem_req_addr !== RESET_PC) begin failures++; $display("FAIL async_req_addr got=%h want=%h", imem_req_addr, RESET_PC); end
        mem_q.delete(); imem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; cyc = 0; exp_req = RESET_PC; exp_dec = RESET_PC;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_req_fire && first) begin
                first = 1'b0;
                checks++; if (s_req_addr !== RESET_PC) begin failures++; $display("FAIL async_restart_addr got=%h want=%h", s_req_addr, RESET_PC); end
            end
            if (s_dec_fire) begin
                checks++; if (s_pc !== exp_dec) begin failures++; $display("FAIL async_pc got=%h want=%h", s_pc, exp_dec); end
                exp_dec += 4; got++;
            end
        end
        checks++; if (got < 5) begin failures++; $display("FAIL async_decode_count got=%0d want>=5", got); end
    endtask

    task automatic test_random();
        int got = 0;
        bit prev_stall = 1'b0;
        logic [63:0] prev_addr = '0;
        apply_reset();
        k_rand = 1'b1;
        for (int i = 0; i < 800; i++) begin
            drv_req_ready   = ($urandom_range(0, 3) != 0);
            drv_instr_ready = ($urandom_range(0, 3) != 0);
            drv_redirect    = ($urandom_range(0, 24) == 0);
            drv_redirect_pc = {$urandom(), $urandom()};
            step();
            if (prev_stall) begin
                checks++; if (s_req_valid !== 1'b1 || s_req_addr !== prev_addr) begin failures++; $display("FAIL rand_req_stable valid=%b addr=%h want 1/%h", s_req_valid, s_req_addr, prev_addr); end
            end
            if (s_req_fire) begin
                checks++; if (s_req_addr !== exp_req) begin failures++; $display("FAIL rand_req_addr got=%h want=%h", s_req_addr, exp_req); end
                exp_req += 4;
            end
            if (s_dec_fire) begin
                checks++; if (s_pc !== exp_dec || s_instr !== mem_word(exp_dec)) begin failures++; $display("FAIL rand_decode pc=%h instr=%h want %h/%h", s_pc, s_instr, exp_dec, mem_word(exp_dec)); end
                exp_dec += 4; got++;
            end
            if (s_redirect) begin
                exp_req = s_rpc & ~64'h3;
                exp_dec = s_rpc & ~64'h3;
            end
            checks++; if (mem_q.size() > D) begin failures++; $display("FAIL rand_outstanding got=%0d want<=%0d", mem_q.size(), D); end
            prev_stall = s_req_valid && !s_req_fire && !s_redirect;
            prev_addr  = s_req_addr;
        end
        drv_redirect = 1'b0;
        checks++; if (got < 100) begin failures++; $display("FAIL rand_progress got=%0d want>=100", got); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_k3();
        test_redirect_collision();
        test_stall();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
